// File: rtl/live_rate_recorder_if.sv
// Strobe, hit and VME read-port bundle for live_rate_recorder.
// spill_total exists only when LRR_SPILL_TOTAL_EN is defined.
interface live_rate_recorder_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned HIT_W  = 4,
  parameter int unsigned ADDR_W = 12
);
  logic              LIVE;
  logic              wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [HIT_W-1:0]  hit_n;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   n_slots;
  logic              spill_done;
  logic              sat_flag;
`ifdef LRR_SPILL_TOTAL_EN
  logic [31:0]       spill_total;

  modport master (
    output LIVE, wr_ena, wr_addr, hit_n, rd_en, rd_addr,
    input  rd_data, rd_valid, n_slots, spill_done, sat_flag, spill_total
  );
  modport slave (
    input  LIVE, wr_ena, wr_addr, hit_n, rd_en, rd_addr,
    output rd_data, rd_valid, n_slots, spill_done, sat_flag, spill_total
  );
`else
  modport master (
    output LIVE, wr_ena, wr_addr, hit_n, rd_en, rd_addr,
    input  rd_data, rd_valid, n_slots, spill_done, sat_flag
  );
  modport slave (
    input  LIVE, wr_ena, wr_addr, hit_n, rd_en, rd_addr,
    output rd_data, rd_valid, n_slots, spill_done, sat_flag
  );
`endif
endinterface

// File: rtl/live_rate_recorder.sv
// Per-slot hit-rate recorder for the LIVE window, with a 2**ADDR_W RAM read back by VME.
// Optional LRR_SPILL_TOTAL_EN adds a saturating 32-bit total of hits over the spill.
module live_rate_recorder #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned HIT_W  = 4,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  live_rate_recorder_if.slave  bus
);
  localparam int unsigned      DEPTH   = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W:0]  NSL_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  NSL_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [ADDR_W:0]   nsl_q, nsl_d;
  logic              sat_q, sat_d;
  logic              s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [CNT_W-1:0]  s1_data_q, s1_data_d;

  logic [CNT_W-1:0]  hit_ext;
  logic [CNT_W:0]    sum_wide;
  logic              sum_ovf;
  logic [CNT_W-1:0]  sum;

  always_comb begin
    hit_ext  = {{(CNT_W-HIT_W){1'b0}}, bus.hit_n};
    sum_wide = {1'b0, acc_q} + {1'b0, hit_ext};
    sum_ovf  = sum_wide[CNT_W];
    sum      = sum_ovf ? CNT_MAX : sum_wide[CNT_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    nsl_d     = nsl_q;
    sat_d     = sat_q;
    s1_vld_d  = 1'b0;
    s1_addr_d = s1_addr_q;
    s1_data_d = s1_data_q;
    case (state_q)
      IDLE: begin
        if (bus.LIVE) begin
          state_d = RUN;
          acc_d   = hit_ext;
          nsl_d   = '0;
          sat_d   = 1'b0;
        end
      end
      RUN: begin
        if (!bus.LIVE) begin
          // Partial slot is dropped; an already-staged write still lands.
          state_d = DONE;
          acc_d   = '0;
        end else begin
          if (sum_ovf) sat_d = 1'b1;
          if (bus.wr_ena) begin
            s1_vld_d  = 1'b1;
            s1_addr_d = bus.wr_addr - A_ONE;
            s1_data_d = sum;
            acc_d     = '0;
            if (nsl_q != NSL_MAX) nsl_d = nsl_q + NSL_ONE;
          end else begin
            acc_d = sum;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      nsl_q    <= '0;
      sat_q    <= 1'b0;
      s1_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      nsl_q    <= nsl_d;
      sat_q    <= sat_d;
      s1_vld_q <= s1_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_addr_q <= s1_addr_d;
    s1_data_q <= s1_data_d;
  end

  // Read-first RAM: the read register samples before the same-edge write updates.
  logic [CNT_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] rd_mem_q, rd_mid_q, rd_data_q;
  logic             rd_v1_q, rd_v2_q, rd_valid_q;

  always_ff @(posedge clk) begin
    if (!reset && s1_vld_q) mem[s1_addr_q] <= s1_data_q;
    rd_mem_q <= mem[bus.rd_addr];
    rd_mid_q <= rd_mem_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v1_q    <= 1'b0;
      rd_v2_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_v1_q    <= bus.rd_en;
      rd_v2_q    <= rd_v1_q;
      rd_valid_q <= rd_v2_q;
      if (rd_v2_q) rd_data_q <= rd_mid_q;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.n_slots    = nsl_q;
  assign bus.sat_flag   = sat_q;
  assign bus.spill_done = (state_q == DONE);

`ifdef LRR_SPILL_TOTAL_EN
  logic [31:0] tot_q, tot_d;
  logic [32:0] tot_wide;

  always_comb begin
    tot_wide = {1'b0, tot_q} + {{(33-HIT_W){1'b0}}, bus.hit_n};
    tot_d    = tot_q;
    if (state_q == IDLE && bus.LIVE)
      tot_d = {{(32-HIT_W){1'b0}}, bus.hit_n};
    else if (state_q == RUN && bus.LIVE)
      tot_d = tot_wide[32] ? '1 : tot_wide[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) tot_q <= '0;
    else       tot_q <= tot_d;
  end

  assign bus.spill_total = tot_q;
`endif
endmodule

// File: tb/tb_live_rate_recorder.sv
// Scoreboard bench for live_rate_recorder: behavioural slot/RAM model feeds expected reads to a monitor.
module tb_live_rate_recorder;
  localparam int CNT_W  = 16;
  localparam int HIT_W  = 4;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam int unsigned CMAX = 65535;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  live_rate_recorder_if #(.CNT_W(CNT_W), .HIT_W(HIT_W), .ADDR_W(ADDR_W)) bus ();
  live_rate_recorder #(.CNT_W(CNT_W), .HIT_W(HIT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: spill phase 0=idle 1=live 2=just ended
  int          mode = 0;
  int unsigned acc = 0;
  int unsigned nsl = 0;
  bit          sat = 1'b0;
  longint unsigned tot = 0;
  int unsigned ref_mem [DEPTH];

  typedef struct { int due; int addr; int unsigned data; } wr_t;
  typedef struct { int due; int unsigned data; } rd_t;
  wr_t wq[$];
  rd_t rq[$];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    int unsigned h;
    int unsigned s;
    h = bus.hit_n;
    if (reset) begin
      mode = 0; acc = 0; nsl = 0; sat = 1'b0; tot = 0;
      wq.delete();
      rq.delete();
      return;
    end
    if (bus.rd_en) rq.push_back('{due: edge_n + 2, data: ref_mem[bus.rd_addr]});
    while (wq.size() > 0 && wq[0].due == edge_n) begin
      ref_mem[wq[0].addr] = wq[0].data;
      void'(wq.pop_front());
    end
    case (mode)
      0: if (bus.LIVE) begin
        mode = 1; acc = h; nsl = 0; sat = 1'b0; tot = h;
      end
      1: if (!bus.LIVE) begin
        mode = 2; acc = 0;
      end else begin
        s = acc + h;
        if (s > CMAX) begin sat = 1'b1; s = CMAX; end
        tot = (tot + h > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : tot + h;
        if (bus.wr_ena) begin
          wq.push_back('{due: edge_n + 1, addr: (int'(bus.wr_addr) + DEPTH - 1) % DEPTH, data: s});
          acc = 0;
          if (nsl < DEPTH) nsl++;
        end else begin
          acc = s;
        end
      end
      default: mode = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    @(negedge clk);
    check("n_slots", bus.n_slots, nsl);
    check("sat_flag", bus.sat_flag, sat);
    check("spill_done", bus.spill_done, (mode == 2));
`ifdef LRR_SPILL_TOTAL_EN
    check("spill_total", bus.spill_total, tot);
`endif
  endtask

  task automatic cyc(input bit live, input bit we, input int wa, input int h, input bit re, input int ra);
    bus.LIVE    = live;
    bus.wr_ena  = we;
    bus.wr_addr = wa[ADDR_W-1:0];
    bus.hit_n   = h[HIT_W-1:0];
    bus.rd_en   = re;
    bus.rd_addr = ra[ADDR_W-1:0];
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every rd_valid must match the oldest expected read at its exact due edge.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (rq.size() == 0 || rq[0].due != edge_n) begin
        checks++; errors++;
        $display("FAIL rd_valid_unexpected: got 1 expected 0 (edge %0d)", edge_n);
      end else begin
        check("rd_data", bus.rd_data, rq[0].data);
        void'(rq.pop_front());
      end
    end else if (rq.size() > 0 && rq[0].due <= edge_n) begin
      checks++; errors++;
      $display("FAIL rd_valid_missing: got 0 expected 1 (edge %0d)", edge_n);
      void'(rq.pop_front());
    end
  end

  initial begin
    int len;
    int a;
    reset = 1'b1;
    bus.LIVE = 0; bus.wr_ena = 0; bus.wr_addr = '0; bus.hit_n = '0;
    bus.rd_en = 0; bus.rd_addr = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    reset = 1'b0;

    // Constant 1 hit per cycle, strobe every 4th LIVE cycle
    for (int i = 1; i <= 12; i++) cyc(1, (i % 4) == 0, i / 4, 1, 0, 0);
    idle(3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, i);
    idle(4);

    // Read coincident with a write of 7 to the same address returns old data
    for (int i = 1; i <= 7; i++) cyc(1, i == 7, 2, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    idle(4);

    // Saturating slot, restart, then a partial slot discarded on LIVE fall
    for (int i = 0; i < 5000; i++) cyc(1, 0, 0, 15, 0, 0);
    cyc(1, 1, 1, 15, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(1, i == 4, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, 0);
    idle(4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, i);
    idle(4);

    // Full wrap: 4097 strobes with random slot lengths and hits
    cyc(1, 0, 0, $urandom_range(0, 15), 0, 0);
    for (int k = 1; k <= 4097; k++) begin
      len = $urandom_range(1, 3);
      for (int j = 1; j <= len; j++)
        cyc(1, j == len, k % DEPTH, $urandom_range(0, 15), 0, 0);
    end
    idle(3);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 4095);
    cyc(0, 0, 0, 0, 1, 4094);
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      cyc(0, 0, 0, 0, 1, a);
    end
    idle(4);

    // Reset in RUN coincident with a strobe
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    reset = 1'b1;
    cyc(1, 1, 5, 1, 0, 0);
    reset = 1'b0;
    check("rst2_rd_data", bus.rd_data, 0);
    check("rst2_rd_valid", bus.rd_valid, 0);
    idle(3);
    cyc(0, 0, 0, 0, 1, 4);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 4095);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/live_rate_recorder.md
Name: live_rate_recorder

Overview:
Downstream consumer of the LIVE-window slot strobe (wr_ena / wr_addr, one pulse per interval, 4096 slots per spill). Accumulates per-cycle hit counts during LIVE. On each strobe it stores the closed slot's count into an internal 4096-entry RAM. The VME side reads that RAM to get a time-resolved rate profile of the spill.

Parameters:
CNT_W, 16, width of each stored slot count and of the accumulator
HIT_W, 4, width of per-cycle hit count input
ADDR_W, 12, slot address width (RAM depth 2**ADDR_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
LIVE  in  1  spill live gate, same signal that drives the strobe generator
wr_ena  in  1  slot-close strobe, one-cycle pulse
wr_addr  in  ADDR_W  strobe address; already incremented on the pulse cycle (first pulse = 1)
hit_n  in  HIT_W  number of hits this cycle
rd_en  in  1  VME read request, one cycle
rd_addr  in  ADDR_W  VME read address
rd_data  out  CNT_W  read data
rd_valid  out  1  rd_data valid pulse
n_slots  out  ADDR_W+1  slots written this spill, saturates at 2**ADDR_W
spill_done  out  1  one-cycle pulse after LIVE falls
sat_flag  out  1  sticky: some slot this spill saturated

Behaviour:
- Reset: state IDLE; acc, n_slots, rd_data = 0; rd_valid, spill_done, sat_flag = 0; pending write dropped. RAM contents are not cleared. Reset wins over wr_ena and rd_en in the same cycle.
- FSM states IDLE, RUN, DONE.
  - IDLE -> RUN when LIVE=1. On entry: acc, n_slots and sat_flag are cleared. Hits in the entry cycle are counted.
  - RUN -> DONE when LIVE=0.
  - DONE -> IDLE unconditionally. spill_done=1 only in DONE.
- Accumulation, each RUN cycle with LIVE=1: sum = acc + hit_n, saturating at 2**CNT_W-1. If saturation occurs, sat_flag is set.
- Slot close, wr_ena=1 in RUN:
  - The slot value is sum, so the pulse-cycle hits belong to the closing slot. acc is cleared to 0.
  - Stage 1 registers data and address = wr_addr-1 mod 2**ADDR_W, so the first pulse writes address 0 and wr_addr=0 writes address 2**ADDR_W-1.
  - Stage 2 writes the RAM. The entry is readable from the cycle after the write edge.
  - n_slots increments, saturating at 2**ADDR_W. Overflow writes wrap and overwrite the oldest entries.
- Otherwise in RUN: acc <= sum.
- wr_ena outside RUN (IDLE/DONE) is ignored.
- LIVE falling mid-slot: the partial acc is discarded, not written. A stage-1 write already pending completes. n_slots and sat_flag hold until the next IDLE->RUN.
- Read port:
  - rd_en sampled at edge N; rd_data and rd_valid appear at edge N+2 (registered RAM read plus output register). rd_valid is 1 for one cycle; rd_data holds until the next read.
  - Reads are allowed in any state.
  - A read and write to the same address on the same edge returns the old data (read-first).
  - Back-to-back rd_en is supported, one result per cycle.

Optional Feature:
Macro LRR_SPILL_TOTAL_EN.
- Defined: adds output spill_total [31:0]. It sums hit_n over every RUN cycle, including the discarded partial slot, and saturates at 0xFFFFFFFF. Cleared on IDLE->RUN and by reset. It holds after the spill.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset; LIVE=1; hit_n=1 constant; wr_ena every 4th LIVE cycle with wr_addr 1,2,3. Required: RAM[0..2]=4; n_slots=3; sat_flag=0.
- hit_n=15 for 5000 RUN cycles, then wr_ena with wr_addr=1. Required: RAM[0]=0xFFFF; sat_flag=1; acc restarts from 0 and the next slot with 4 hits stores 4.
- 4097 pulses with wr_addr 1..4095,0,1 and a distinct per-slot hit pattern. Required: pulse 4096 writes address 4095; pulse 4097 overwrites address 0; n_slots=4096.
- LIVE drops with acc=3 mid-slot. Required: no RAM write; spill_done=1 exactly one cycle later; n_slots held; next LIVE rise gives n_slots=0 and sat_flag=0.
- rd_en with rd_addr=1 after the first scenario. Required: rd_valid and rd_data=4 exactly 2 cycles later. The same read coincident with a stage-2 write of 7 to address 1 returns 4.
- Reset asserted in RUN with acc=2 and wr_ena=1 in the same cycle. Required: state IDLE; all outputs 0; RAM[wr_addr-1] unchanged; previously written entries still readable.
